// File: rtl/fpu_addsub.sv
// Parametrised IEEE-754 adder/subtractor, round-to-nearest-even, with flags.
// Ports: clk, rst (async high); A/B/Z stb-ack channels; input_op (0 add, 1 sub); output_z_flags {inv,ovf,unf,inx}.
module fpu_addsub #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  input  logic [WIDTH-1:0] input_b,
  input  logic             input_op,
  input  logic             input_b_stb,
  output logic             input_b_ack,
  output logic [WIDTH-1:0] output_z,
  output logic [3:0]       output_z_flags,
  output logic             output_z_stb,
  input  logic             output_z_ack
);
  // SW: hidden bit + fraction + guard/round/sticky
  localparam int SW = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam int LZW = $clog2(SW + 1);
  localparam logic [EXP_W-1:0] EONES = '1;
  localparam logic [WIDTH-1:0] QNAN =
    {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    GET_A, GET_B, UNPACK, ALIGN, ADD, NORM, ROUND, PUT_Z
  } state_t;

  state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic op_r;
  logic a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W:0] a_m, b_m;
  logic sp;
  logic [WIDTH-1:0] sp_z;
  logic [3:0] sp_f;
  logic x_s, y_s;
  logic [EXP_W-1:0] x_e;
  logic [SW-1:0] x_m, y_m;
  logic [SW:0] sum;
  logic s_s, s_zs;
  logic [EXP_W-1:0] s_e;
  logic [SW-1:0] n_m;
  logic [EW-1:0] n_e;
  logic n_s, n_z;

  logic [EXP_W-1:0] ua_e, ub_e;
  logic [MAN_W-1:0] ua_f, ub_f;
  logic ub_s, a_inf, a_nan, b_inf, b_nan;
  logic u_sp;
  logic [WIDTH-1:0] u_z;
  logic [3:0] u_f;

  assign ua_e = a_r[WIDTH-2 -: EXP_W];
  assign ub_e = b_r[WIDTH-2 -: EXP_W];
  assign ua_f = a_r[MAN_W-1:0];
  assign ub_f = b_r[MAN_W-1:0];
  assign ub_s = b_r[WIDTH-1] ^ op_r;
  assign a_inf = (&ua_e) & ~(|ua_f);
  assign a_nan = (&ua_e) & (|ua_f);
  assign b_inf = (&ub_e) & ~(|ub_f);
  assign b_nan = (&ub_e) & (|ub_f);

  always_comb begin
    u_sp = 1'b1;
    u_z = QNAN;
    u_f = 4'b1000;
    if (a_nan | b_nan | (a_inf & b_inf & (a_r[WIDTH-1] != ub_s))) begin
      u_z = QNAN;
    end else if (a_inf) begin
      u_z = {a_r[WIDTH-1], EONES, {MAN_W{1'b0}}};
      u_f = 4'b0000;
    end else if (b_inf) begin
      u_z = {ub_s, EONES, {MAN_W{1'b0}}};
      u_f = 4'b0000;
    end else begin
      u_sp = 1'b0;
      u_f = 4'b0000;
    end
  end

  // order operands by magnitude so the subtract never goes negative
  logic swap, lost;
  logic [EXP_W-1:0] hi_e, lo_e, dif;
  logic [MAN_W:0] hi_m, lo_m;
  logic [SW-1:0] lo_x, lo_sh, lo_al;

  always_comb begin
    swap = (b_e > a_e) || ((b_e == a_e) && (b_m > a_m));
    hi_e = swap ? b_e : a_e;
    lo_e = swap ? a_e : b_e;
    hi_m = swap ? b_m : a_m;
    lo_m = swap ? a_m : b_m;
    dif = hi_e - lo_e;
    lo_x = {lo_m, 3'b000};
    lo_sh = lo_x >> dif;
    lost = |(lo_x & ~({SW{1'b1}} << dif));
    lo_al = {lo_sh[SW-1:1], lo_sh[0] | lost};
  end

  logic [LZW-1:0] lz;

  always_comb begin
    lz = LZW'(SW);
    for (int i = 0; i < SW; i++)
      if (sum[i]) lz = LZW'(SW - 1 - i);
  end

  logic g, r, st, up, inx;
  logic [MAN_W+1:0] rm;
  logic [EW-1:0] re;
  logic [MAN_W-1:0] rf;
  logic [WIDTH-1:0] rz;
  logic [3:0] rfl;

  always_comb begin
    g = n_m[2];
    r = n_m[1];
    st = n_m[0];
    inx = g | r | st;
    up = g & (r | st | n_m[3]);
    rm = {1'b0, n_m[SW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    re = rm[MAN_W+1] ? n_e + EW'(1) : n_e;
    rf = rm[MAN_W+1] ? rm[MAN_W:1] : rm[MAN_W-1:0];
    rz = {n_s, re[EXP_W-1:0], rf};
    rfl = {3'b000, inx};
    if (sp) begin
      rz = sp_z;
      rfl = sp_f;
    end else if (n_z) begin
      rz = {n_s, {(WIDTH-1){1'b0}}};
      rfl = 4'b0000;
    end else if (re[EW-1] || re == '0) begin
      rz = {n_s, {(WIDTH-1){1'b0}}};
      rfl = 4'b0011;
    end else if (re[EW-2:0] >= {1'b0, EONES}) begin
      rz = {n_s, EONES, {MAN_W{1'b0}}};
      rfl = 4'b0101;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GET_A;
      input_a_ack <= 1'b0;
      input_b_ack <= 1'b0;
      output_z <= '0;
      output_z_flags <= '0;
      output_z_stb <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      op_r <= 1'b0;
      a_s <= 1'b0;
      b_s <= 1'b0;
      a_e <= '0;
      b_e <= '0;
      a_m <= '0;
      b_m <= '0;
      sp <= 1'b0;
      sp_z <= '0;
      sp_f <= '0;
      x_s <= 1'b0;
      y_s <= 1'b0;
      x_e <= '0;
      x_m <= '0;
      y_m <= '0;
      sum <= '0;
      s_s <= 1'b0;
      s_zs <= 1'b0;
      s_e <= '0;
      n_m <= '0;
      n_e <= '0;
      n_s <= 1'b0;
      n_z <= 1'b0;
    end else begin
      unique case (state)
        GET_A: begin
          if (input_a_ack && input_a_stb) begin
            a_r <= input_a;
            input_a_ack <= 1'b0;
            input_b_ack <= 1'b1;
            state <= GET_B;
          end else begin
            input_a_ack <= 1'b1;
          end
        end
        GET_B: begin
          if (input_b_ack && input_b_stb) begin
            b_r <= input_b;
            op_r <= input_op;
            input_b_ack <= 1'b0;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          a_s <= a_r[WIDTH-1];
          b_s <= ub_s;
          a_e <= ua_e;
          b_e <= ub_e;
          // exponent 0 flushes denormals to signed zero
          a_m <= (ua_e == '0) ? '0 : {1'b1, ua_f};
          b_m <= (ub_e == '0) ? '0 : {1'b1, ub_f};
          sp <= u_sp;
          sp_z <= u_z;
          sp_f <= u_f;
          state <= ALIGN;
        end
        ALIGN: begin
          x_s <= swap ? b_s : a_s;
          y_s <= swap ? a_s : b_s;
          x_e <= hi_e;
          x_m <= {hi_m, 3'b000};
          y_m <= lo_al;
          state <= ADD;
        end
        ADD: begin
          sum <= (x_s == y_s) ? {1'b0, x_m} + {1'b0, y_m}
                              : {1'b0, x_m} - {1'b0, y_m};
          s_s <= x_s;
          // an exact zero is negative only when both inputs were
          s_zs <= x_s & y_s;
          s_e <= x_e;
          state <= NORM;
        end
        NORM: begin
          if (sum[SW]) begin
            n_m <= {sum[SW:2], sum[1] | sum[0]};
            n_e <= EW'(s_e) + EW'(1);
          end else begin
            n_m <= sum[SW-1:0] << lz;
            n_e <= EW'(s_e) - EW'(lz);
          end
          n_z <= (sum == '0);
          n_s <= (sum == '0) ? s_zs : s_s;
          state <= ROUND;
        end
        ROUND: begin
          output_z <= rz;
          output_z_flags <= rfl;
          output_z_stb <= 1'b1;
          state <= PUT_Z;
        end
        PUT_Z: begin
          if (output_z_ack) begin
            output_z_stb <= 1'b0;
            input_a_ack <= 1'b1;
            state <= GET_A;
          end
        end
        default: state <= GET_A;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_addsub.sv
// Bench for fpu_addsub: half, single and double instances run in lockstep.
// Directed vectors plus random operands against a real-arithmetic model.
module tb_fpu_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_stb = 1'b0, b_stb = 1'b0, op = 1'b0, z_ack = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, z16o;
  logic [31:0] a32 = '0, b32 = '0, z32o;
  logic [63:0] a64 = '0, b64 = '0, z64o;
  logic [3:0] f16o, f32o, f64o;
  logic s16, s32, s64, aa16, aa32, aa64, ba16, ba32, ba64;

  int checks = 0;
  int errors = 0;
  logic [63:0] r16, r32, r64;
  logic [3:0] g16, g32, g64;

  fpu_addsub #(.EXP_W(5), .MAN_W(10)) u16 (
    .clk(clk), .rst(rst),
    .input_a(a16), .input_a_stb(a_stb), .input_a_ack(aa16),
    .input_b(b16), .input_op(op), .input_b_stb(b_stb), .input_b_ack(ba16),
    .output_z(z16o), .output_z_flags(f16o), .output_z_stb(s16),
    .output_z_ack(z_ack));

  fpu_addsub u32 (
    .clk(clk), .rst(rst),
    .input_a(a32), .input_a_stb(a_stb), .input_a_ack(aa32),
    .input_b(b32), .input_op(op), .input_b_stb(b_stb), .input_b_ack(ba32),
    .output_z(z32o), .output_z_flags(f32o), .output_z_stb(s32),
    .output_z_ack(z_ack));

  fpu_addsub #(.EXP_W(11), .MAN_W(52)) u64 (
    .clk(clk), .rst(rst),
    .input_a(a64), .input_a_stb(a_stb), .input_a_ack(aa64),
    .input_b(b64), .input_op(op), .input_b_stb(b_stb), .input_b_ack(ba64),
    .output_z(z64o), .output_z_flags(f64o), .output_z_stb(s64),
    .output_z_ack(z_ack));

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic real to_real(int ew, int mw, logic [63:0] x);
    int bias, e;
    logic s;
    logic [63:0] f;
    logic [10:0] de;
    logic [51:0] df;
    bias = (1 << (ew - 1)) - 1;
    s = x[ew + mw];
    e = int'((x >> mw) & ((64'd1 << ew) - 1));
    f = x & ((64'd1 << mw) - 1);
    if (e == 0) return $bitstoreal({s, 63'd0});
    de = 11'(e - bias + 1023);
    df = 52'(f << (52 - mw));
    return $bitstoreal({s, de, df});
  endfunction

  // round an exactly representable real to the target format, RNE,
  // flushing sub-normal results to signed zero
  function automatic logic [63:0] from_real(int ew, int mw, real v);
    logic [63:0] d, sig, kept, rem, half, sb;
    int bias, te, drop;
    d = $realtobits(v);
    sb = 64'(d[63]) << (ew + mw);
    if (d[62:0] == '0) return sb;
    bias = (1 << (ew - 1)) - 1;
    drop = 52 - mw;
    sig = {11'd0, 1'b1, d[51:0]};
    kept = sig >> drop;
    rem = sig & ((64'd1 << drop) - 1);
    half = 64'd1 << (drop - 1);
    if (rem > half || (rem == half && kept[0])) kept++;
    te = int'(d[62:52]) - 1023 + bias;
    if (kept == (64'd1 << (mw + 1))) begin
      kept = kept >> 1;
      te++;
    end
    if (te >= (1 << ew) - 1)
      return sb | (((64'd1 << ew) - 1) << mw);
    if (te <= 0) return sb;
    return sb | (64'(te) << mw) | (kept & ((64'd1 << mw) - 1));
  endfunction

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic run(input logic [15:0] ha, input logic [15:0] hb,
                     input logic [31:0] sa, input logic [31:0] sb,
                     input logic [63:0] da, input logic [63:0] db,
                     input logic o, input int hold);
    int n;
    logic stable;
    a16 = ha; a32 = sa; a64 = da;
    a_stb = 1'b1;
    n = 0;
    while (!aa32 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("a_ack", 64'(aa32), 64'd1);
    @(posedge clk); #1;
    a_stb = 1'b0;
    a16 = 16'($urandom); a32 = $urandom; a64 = {$urandom, $urandom};
    b16 = hb; b32 = sb; b64 = db; op = o;
    b_stb = 1'b1;
    chk("b_ack", 64'({ba32, aa32}), 64'd2);
    @(posedge clk); #1;
    b_stb = 1'b0;
    b16 = 16'($urandom); b32 = $urandom; b64 = {$urandom, $urandom};
    op = 1'($urandom);
    n = 0;
    while (!s32 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 64'(n), 64'd5);
    chk("stb_all", 64'({s16, s64}), 64'd3);
    r16 = 64'(z16o); r32 = 64'(z32o); r64 = z64o;
    g16 = f16o; g32 = f32o; g64 = f64o;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (64'(z32o) !== r32 || f32o !== g32 || aa32 || ba32 || !s32)
        stable = 1'b0;
    end
    if (hold > 0) chk("hold", 64'(stable), 64'd1);
    z_ack = 1'b1;
    @(posedge clk); #1;
    z_ack = 1'b0;
    chk("ack_edge", 64'({s32, aa32}), 64'd1);
  endtask

  initial begin
    logic [15:0] ha, hb;
    logic [31:0] sa, sb;
    logic [63:0] da, db, t;
    logic o, stb_seen;
    int ea, eb;
    real ra, rb;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_z", {z16o, z32o, 16'd0}, 64'd0);
    chk("rst_z64", z64o, 64'd0);
    chk("rst_ctl", 64'({f32o, s32, aa32, ba32}), 64'd0);
    rst = 1'b0;
    chk("aack_pre", 64'(aa32), 64'd0);
    @(posedge clk); #1;
    chk("aack_rise", 64'(aa32), 64'd1);

    run(16'h3C00, 16'h3C00, 32'h3F800000, 32'h40000000,
        64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 10);
    chk("add_h", r16, 64'h4000);
    chk("add_s", r32, 64'h40400000);
    chk("add_s_f", 64'(g32), 64'd0);
    chk("add_d", r64, 64'h4008000000000000);

    run(16'h3C00, 16'h3C00, 32'h3F800000, 32'h3F800000,
        64'h3FF0000000000000, 64'h4000000000000000, 1'b1, 0);
    chk("sub_h", r16, 64'h0000);
    chk("sub_s", r32, 64'h00000000);
    chk("sub_d", r64, 64'hBFF0000000000000);

    run(16'h0, 16'h0, 32'h3F800000, 32'h33800000, 64'h0, 64'h0, 1'b0, 0);
    chk("tie_even", {r32[31:0], 28'd0, g32}, {32'h3F800000, 32'd1});
    run(16'h0, 16'h0, 32'h3F800001, 32'h33800000, 64'h0, 64'h0, 1'b0, 0);
    chk("tie_up", {r32[31:0], 28'd0, g32}, {32'h3F800002, 32'd1});
    run(16'h0, 16'h0, 32'h7F800000, 32'hFF800000, 64'h0, 64'h0, 1'b0, 0);
    chk("inf_inf", {r32[31:0], 28'd0, g32}, {32'h7FC00000, 32'd8});
    run(16'h0, 16'h0, 32'h7F7FFFFF, 32'h7F7FFFFF, 64'h0, 64'h0, 1'b0, 3);
    chk("ovf", {r32[31:0], 28'd0, g32}, {32'h7F800000, 32'd5});
    run(16'h0, 16'h0, 32'h00400000, 32'h00000000, 64'h0, 64'h0, 1'b0, 0);
    chk("denorm", {r32[31:0], 28'd0, g32}, {32'h00000000, 32'd0});
    run(16'h0, 16'h0, 32'h80000000, 32'h80000000, 64'h0, 64'h0, 1'b0, 0);
    chk("neg_zero", r32, 64'h80000000);
    run(16'h0, 16'h0, 32'h7F800000, 32'h3F800000, 64'h0, 64'h0, 1'b1, 0);
    chk("inf_fin", {r32[31:0], 28'd0, g32}, {32'h7F800000, 32'd0});
    run(16'h0, 16'h0, 32'h3F800000, 32'h7FC00001, 64'h0, 64'h0, 1'b0, 0);
    chk("nan_in", {r32[31:0], 28'd0, g32}, {32'h7FC00000, 32'd8});
    run(16'h0, 16'h0, 32'h00800001, 32'h00800000, 64'h0, 64'h0, 1'b1, 0);
    chk("unf", {r32[31:0], 28'd0, g32}, {32'h00000000, 32'd3});

    a32 = 32'h3F800000;
    a_stb = 1'b1;
    @(posedge clk); #1;
    a_stb = 1'b0;
    b32 = 32'h40000000;
    b_stb = 1'b1;
    @(posedge clk); #1;
    b_stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_z", {z16o, z32o, 16'd0}, 64'd0);
    chk("rst_mid_ctl", 64'({f32o, s32, aa32, ba32}), 64'd0);
    stb_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      stb_seen = stb_seen | s32 | s16 | s64;
    end
    rst = 1'b0;
    chk("rel_pre", 64'(aa32), 64'd0);
    @(posedge clk); #1;
    chk("rel_aack", 64'(aa32), 64'd1);
    repeat (8) begin
      @(posedge clk); #1;
      stb_seen = stb_seen | s32 | s16 | s64;
    end
    chk("abort_nostb", 64'(stb_seen), 64'd0);
    run(16'h3C00, 16'h3C00, 32'h3F800000, 32'h40000000,
        64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 0);
    chk("post_rst", r32, 64'h40400000);

    for (int it = 0; it < 1000; it++) begin
      o = 1'($urandom);
      ea = $urandom_range(1, 30);
      eb = clampi(ea + $urandom_range(0, 12) - 6, 1, 30);
      ha = {1'($urandom), 5'(ea), 10'($urandom)};
      hb = {1'($urandom), 5'(eb), 10'($urandom)};
      ea = $urandom_range(1, 254);
      eb = clampi(ea + $urandom_range(0, 48) - 24, 1, 254);
      sa = {1'($urandom), 8'(ea), 23'($urandom)};
      sb = {1'($urandom), 8'(eb), 23'($urandom)};
      if (($urandom & 7) == 0)
        sb = {1'($urandom), sa[30:4], 4'($urandom)};
      ea = $urandom_range(100, 1900);
      eb = clampi(ea + $urandom_range(0, 140) - 70, 1, 2046);
      t = {$urandom, $urandom};
      da = {1'($urandom), 11'(ea), t[51:0]};
      t = {$urandom, $urandom};
      db = {1'($urandom), 11'(eb), t[51:0]};
      if (($urandom & 7) == 0)
        db = {1'($urandom), da[62:6], 6'($urandom)};
      run(ha, hb, sa, sb, da, db, o, 0);
      ra = to_real(5, 10, 64'(ha));
      rb = to_real(5, 10, 64'(hb));
      chk("rnd16", r16, from_real(5, 10, o ? ra - rb : ra + rb));
      ra = to_real(8, 23, 64'(sa));
      rb = to_real(8, 23, 64'(sb));
      chk("rnd32", r32, from_real(8, 23, o ? ra - rb : ra + rb));
      ra = $bitstoreal(da);
      rb = $bitstoreal(db);
      chk("rnd64", r64, $realtobits(o ? ra - rb : ra + rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
